// File: rtl/apb_master_sched_if.sv
// Requester and APB bus bundle for apb_master_sched.
// master = scheduler view, slave = requesters plus muxed APB slaves.
interface apb_master_sched_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 3
);
  logic [1:0]            i_req_valid;
  logic [1:0]            o_req_ready;
  logic [ADDR_WIDTH-1:0] i_req_addr_0;
  logic [ADDR_WIDTH-1:0] i_req_addr_1;
  logic [1:0]            i_req_write;
  logic [DATA_WIDTH-1:0] i_req_wdata_0;
  logic [DATA_WIDTH-1:0] i_req_wdata_1;
  logic [1:0]            o_rsp_valid;
  logic [DATA_WIDTH-1:0] o_rsp_rdata;
  logic                  o_rsp_error;
  logic [SEL_WIDTH-1:0]  o_psel;
  logic                  o_penable;
  logic [ADDR_WIDTH-1:0] o_paddr;
  logic                  o_pwrite;
  logic [DATA_WIDTH-1:0] o_pwdata;
  logic [DATA_WIDTH-1:0] i_prdata;
  logic                  i_pready;
  logic                  i_pslverr;

  modport master (
    input  i_req_valid,
    output o_req_ready,
    input  i_req_addr_0,
    input  i_req_addr_1,
    input  i_req_write,
    input  i_req_wdata_0,
    input  i_req_wdata_1,
    output o_rsp_valid,
    output o_rsp_rdata,
    output o_rsp_error,
    output o_psel,
    output o_penable,
    output o_paddr,
    output o_pwrite,
    output o_pwdata,
    input  i_prdata,
    input  i_pready,
    input  i_pslverr
  );

  modport slave (
    output i_req_valid,
    input  o_req_ready,
    output i_req_addr_0,
    output i_req_addr_1,
    output i_req_write,
    output i_req_wdata_0,
    output i_req_wdata_1,
    input  o_rsp_valid,
    input  o_rsp_rdata,
    input  o_rsp_error,
    input  o_psel,
    input  o_penable,
    input  o_paddr,
    input  o_pwrite,
    input  o_pwdata,
    output i_prdata,
    output i_pready,
    output i_pslverr
  );
endinterface

// File: rtl/apb_master_sched.sv
// Two-requester round-robin APB master with address decode,
// SETUP/ACCESS sequencing, PREADY timeout and per-owner response.
module apb_master_sched #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 3,
  parameter int TIMEOUT    = 16
) (
  input logic              i_clk,
  input logic              i_rst,
  apb_master_sched_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t                state_q;
  logic                  prio_q;
  logic                  owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SEL_WIDTH-1:0]  psel_q;
  logic                  penable_q;
  logic [1:0]            rspv_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CW-1:0]         cnt_q;

  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_write;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [SEL_WIDTH-1:0]  req_sel;
  logic [1:0]            own_oh;
  logic                  tmo;

  // prio_q names the requester that wins a tie
  always_comb begin
    gnt = 2'b00;
    if (state_q == IDLE) begin
      unique case (1'b1)
        (bus.i_req_valid == 2'b11): gnt = prio_q ? 2'b10 : 2'b01;
        (bus.i_req_valid == 2'b01): gnt = 2'b01;
        (bus.i_req_valid == 2'b10): gnt = 2'b10;
        default:                    gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    req_addr  = gnt[1] ? bus.i_req_addr_1  : bus.i_req_addr_0;
    req_write = gnt[1] ? bus.i_req_write[1] : bus.i_req_write[0];
    req_wdata = gnt[1] ? bus.i_req_wdata_1 : bus.i_req_wdata_0;
  end

  always_comb begin
    req_sel = '0;
    unique case (req_addr[13:12])
      2'b00:   req_sel = SEL_WIDTH'(1);
      2'b01:   req_sel = SEL_WIDTH'(2);
      2'b10:   req_sel = SEL_WIDTH'(4);
      default: req_sel = '0;
    endcase
  end

  assign own_oh = owner_q ? 2'b10 : 2'b01;
  assign tmo    = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      rspv_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            owner_q <= gnt[1];
            prio_q  <= ~gnt[1];
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            if (req_sel == '0) begin
              rspv_q  <= gnt;
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= RESP;
            end else begin
              psel_q  <= req_sel;
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.i_pready) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            rspv_q    <= own_oh;
            err_q     <= bus.i_pslverr;
            rdata_q   <= (write_q || bus.i_pslverr) ? '0 : bus.i_prdata;
            state_q   <= RESP;
          end else if (tmo) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            rspv_q    <= own_oh;
            err_q     <= 1'b1;
            rdata_q   <= '0;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          rspv_q  <= 2'b00;
          err_q   <= 1'b0;
          rdata_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = gnt;
  assign bus.o_rsp_valid = rspv_q;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_error = err_q;
  assign bus.o_psel      = psel_q;
  assign bus.o_penable   = penable_q;
  assign bus.o_paddr     = addr_q;
  assign bus.o_pwrite    = write_q;
  assign bus.o_pwdata    = wdata_q;

endmodule

// File: tb/tb_apb_master_sched.sv
// Directed bench for apb_master_sched: vector table of single
// transactions plus reset, timeout and round-robin sequences.
module tb_apb_master_sched;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  apb_master_sched_if #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .SEL_WIDTH (3)
  ) bus ();

  apb_master_sched #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .SEL_WIDTH (3),
    .TIMEOUT   (TMO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    int          r;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic [2:0]  sel;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt[6];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".ready"},  64'(bus.o_req_ready), 64'd0);
    chk({tag, ".rspv"},   64'(bus.o_rsp_valid), 64'd0);
    chk({tag, ".rdata"},  64'(bus.o_rsp_rdata), 64'd0);
    chk({tag, ".err"},    64'(bus.o_rsp_error), 64'd0);
    chk({tag, ".psel"},   64'(bus.o_psel), 64'd0);
    chk({tag, ".pen"},    64'(bus.o_penable), 64'd0);
    chk({tag, ".paddr"},  64'(bus.o_paddr), 64'd0);
    chk({tag, ".pwrite"}, 64'(bus.o_pwrite), 64'd0);
    chk({tag, ".pwdata"}, 64'(bus.o_pwdata), 64'd0);
  endtask

  task automatic do_txn(input vec_t v);
    logic [1:0] oh;
    oh = (v.r == 1) ? 2'b10 : 2'b01;
    bus.i_req_valid    = oh;
    bus.i_req_write[v.r] = v.wr;
    if (v.r == 1) begin
      bus.i_req_addr_1  = v.addr;
      bus.i_req_wdata_1 = v.wdata;
    end else begin
      bus.i_req_addr_0  = v.addr;
      bus.i_req_wdata_0 = v.wdata;
    end
    #1;
    chk("grant", 64'(bus.o_req_ready), 64'(oh));
    step;
    bus.i_req_valid = 2'b00;
    if (v.sel == 3'b000) begin
      chk("decerr.rspv", 64'(bus.o_rsp_valid), 64'(oh));
      chk("decerr.err",  64'(bus.o_rsp_error), 64'd1);
      chk("decerr.psel", 64'(bus.o_psel), 64'd0);
    end else begin
      chk("setup.psel",  64'(bus.o_psel), 64'(v.sel));
      chk("setup.pen",   64'(bus.o_penable), 64'd0);
      chk("setup.paddr", 64'(bus.o_paddr), 64'(v.addr));
      chk("setup.pwr",   64'(bus.o_pwrite), 64'(v.wr));
      if (v.wr)
        chk("setup.pwdata", 64'(bus.o_pwdata), 64'(v.wdata));
      step;
      for (int w = 0; w < v.waits; w++) begin
        bus.i_pready  = 1'b0;
        bus.i_prdata  = 32'hBAD0_0000 + 32'(w);
        bus.i_pslverr = 1'b1;
        chk("wait.psel", 64'(bus.o_psel), 64'(v.sel));
        chk("wait.pen",  64'(bus.o_penable), 64'd1);
        chk("wait.rspv", 64'(bus.o_rsp_valid), 64'd0);
        step;
      end
      if (v.waits < TMO) begin
        bus.i_pready  = 1'b1;
        bus.i_prdata  = v.prdata;
        bus.i_pslverr = v.slverr;
        chk("acc.psel", 64'(bus.o_psel), 64'(v.sel));
        chk("acc.pen",  64'(bus.o_penable), 64'd1);
        step;
      end
      bus.i_pready  = 1'b0;
      bus.i_pslverr = 1'b0;
      chk("resp.rspv", 64'(bus.o_rsp_valid), 64'(oh));
      chk("resp.psel", 64'(bus.o_psel), 64'd0);
      chk("resp.pen",  64'(bus.o_penable), 64'd0);
    end
    chk("resp.rdata", 64'(bus.o_rsp_rdata), 64'(v.rdata));
    chk("resp.err",   64'(bus.o_rsp_error), 64'(v.err));
    step;
    chk("post.rspv", 64'(bus.o_rsp_valid), 64'd0);
    chk("post.psel", 64'(bus.o_psel), 64'd0);
  endtask

  initial begin
    vt[0] = '{0, 32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0,
              32'hFFFF_0000, 3'b010, 32'h0, 1'b0};
    vt[1] = '{1, 32'h0000_2000, 1'b0, 32'h0, 3, 1'b0,
              32'h1234_5678, 3'b100, 32'h1234_5678, 1'b0};
    vt[2] = '{0, 32'h0000_3000, 1'b0, 32'h0, 0, 1'b0,
              32'h0, 3'b000, 32'h0, 1'b1};
    vt[3] = '{1, 32'h0000_0000, 1'b0, 32'h0, 0, 1'b1,
              32'hAAAA_5555, 3'b001, 32'h0, 1'b1};
    vt[4] = '{0, 32'h0000_1ABC, 1'b0, 32'h0, TMO, 1'b0,
              32'h0, 3'b010, 32'h0, 1'b1};
    vt[5] = '{1, 32'h0000_2FF0, 1'b1, 32'h5A5A_0F0F, 1, 1'b0,
              32'h7777_7777, 3'b100, 32'h0, 1'b0};

    bus.i_req_valid   = 2'b00;
    bus.i_req_write   = 2'b00;
    bus.i_req_addr_0  = '0;
    bus.i_req_addr_1  = '0;
    bus.i_req_wdata_0 = '0;
    bus.i_req_wdata_1 = '0;
    bus.i_prdata      = '0;
    bus.i_pready      = 1'b0;
    bus.i_pslverr     = 1'b0;

    step;
    step;
    chk_idle_outs("rst");
    rst = 1'b0;
    step;

    for (int i = 0; i < 6; i++) do_txn(vt[i]);

    // reset while in ACCESS: requester 0 granted, pointer then favours 1
    bus.i_req_valid  = 2'b01;
    bus.i_req_addr_0 = 32'h0000_0004;
    bus.i_req_write  = 2'b00;
    #1;
    chk("mrst.grant", 64'(bus.o_req_ready), 64'd1);
    step;
    bus.i_req_valid = 2'b00;
    step;
    chk("mrst.pen", 64'(bus.o_penable), 64'd1);
    rst = 1'b1;
    step;
    chk_idle_outs("mrst");
    rst = 1'b0;
    step;
    chk("mrst.norsp", 64'(bus.o_rsp_valid), 64'd0);

    // both requesters valid throughout: grants alternate from 0
    bus.i_req_addr_0 = 32'h0000_0010;
    bus.i_req_addr_1 = 32'h0000_1020;
    bus.i_req_write  = 2'b00;
    bus.i_prdata     = 32'h0000_00C3;
    bus.i_pready     = 1'b1;
    bus.i_req_valid  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]  oh;
      logic [31:0] ea;
      oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      ea = (k % 2 == 0) ? 32'h0000_0010 : 32'h0000_1020;
      #1;
      chk("rr.grant", 64'(bus.o_req_ready), 64'(oh));
      step;
      chk("rr.setup.paddr", 64'(bus.o_paddr), 64'(ea));
      chk("rr.setup.ready", 64'(bus.o_req_ready), 64'd0);
      step;
      chk("rr.acc.ready", 64'(bus.o_req_ready), 64'd0);
      step;
      chk("rr.rspv",  64'(bus.o_rsp_valid), 64'(oh));
      chk("rr.rdata", 64'(bus.o_rsp_rdata), 64'h0000_00C3);
      chk("rr.ready", 64'(bus.o_req_ready), 64'd0);
      step;
    end
    bus.i_req_valid = 2'b00;
    bus.i_pready    = 1'b0;
    step;
    chk("end.psel", 64'(bus.o_psel), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
